// File: rtl/punc_control.sv
// Purpose: FSM control unit for the PUnC LC3 core; decodes IR and NZP into datapath controls.
// Latency: 3 cycles per instruction (FETCH, DECODE, EXEC), 4 for LDI/STI (adds EXEC2).
// Backpressure: none; memory and register file are single-cycle, so the FSM never stalls.
module punc_control #(
    parameter logic [7:0] HALT_VECT = 8'h25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ir,
    input  logic        n_flag,
    input  logic        z_flag,
    input  logic        p_flag,
    output logic        pc_ld,
    output logic        pc_inc,
    output logic        pc_data_sel,
    output logic        pc_add_sel,
    output logic        ir_ld,
    output logic [1:0]  mem_addr_sel,
    output logic        mem_w_en,
    output logic        store_ld,
    output logic [2:0]  rf_r_addr_0,
    output logic [2:0]  rf_r_addr_1,
    output logic [2:0]  rf_w_addr,
    output logic        rf_w_en,
    output logic [1:0]  rf_w_sel,
    output logic        a_sel,
    output logic        b_sel,
    output logic [1:0]  sext_sel,
    output logic [1:0]  alu_sel,
    output logic        nzp_ld,
    output logic        halted
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        EXEC2  = 3'd3,
        HALT   = 3'd4
    } state_t;

    // Opcodes (ir[15:12])
    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_LDI  = 4'b1010;
    localparam logic [3:0] OP_STI  = 4'b1011;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_LEA  = 4'b1110;

    // Datapath mux encodings
    localparam logic [1:0] MEM_PC    = 2'b00;
    localparam logic [1:0] MEM_ALU   = 2'b01;
    localparam logic [1:0] MEM_STORE = 2'b10;

    localparam logic [1:0] W_PC  = 2'b00;
    localparam logic [1:0] W_MEM = 2'b01;
    localparam logic [1:0] W_ALU = 2'b10;

    localparam logic [1:0] SEXT_IMM5  = 2'b00;
    localparam logic [1:0] SEXT_OFF6  = 2'b01;
    localparam logic [1:0] SEXT_OFF9  = 2'b10;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_AND  = 2'b01;
    localparam logic [1:0] ALU_NOT  = 2'b10;
    localparam logic [1:0] ALU_PASS = 2'b11;

    localparam logic [15:0] HALT_INSTR = {4'b1111, 4'b0000, HALT_VECT};

    state_t     state;
    logic [3:0] opcode;
    logic [2:0] dr;
    logic [2:0] base;
    logic       br_taken;

    assign opcode   = ir[15:12];
    assign dr       = ir[11:9];
    assign base     = ir[8:6];
    assign br_taken = (ir[11] & n_flag) | (ir[10] & z_flag) | (ir[9] & p_flag);

    // State register: sequence FETCH->DECODE->EXEC[->EXEC2]->FETCH; HALT is sticky until reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH:   state <= DECODE;
                DECODE:  state <= (ir == HALT_INSTR) ? HALT : EXEC;
                EXEC:    state <= (opcode == OP_LDI || opcode == OP_STI) ? EXEC2 : FETCH;
                EXEC2:   state <= FETCH;
                HALT:    state <= HALT;
                default: state <= FETCH;
            endcase
        end
    end

    // Control decode: outputs follow state and IR combinationally so an async reset
    // drops any write strobe in the same instant it lands.
    always_comb begin
        pc_ld        = 1'b0;
        pc_inc       = 1'b0;
        pc_data_sel  = 1'b0;
        pc_add_sel   = 1'b0;
        ir_ld        = 1'b0;
        mem_addr_sel = MEM_PC;
        mem_w_en     = 1'b0;
        store_ld     = 1'b0;
        rf_r_addr_0  = 3'd0;
        rf_r_addr_1  = 3'd0;
        rf_w_addr    = 3'd0;
        rf_w_en      = 1'b0;
        rf_w_sel     = W_PC;
        a_sel        = 1'b0;
        b_sel        = 1'b0;
        sext_sel     = SEXT_IMM5;
        alu_sel      = ALU_ADD;
        nzp_ld       = 1'b0;
        halted       = 1'b0;

        case (state)
            FETCH: begin
                ir_ld        = 1'b1;
                pc_inc       = 1'b1;
                mem_addr_sel = MEM_PC;
            end

            DECODE: begin
            end

            EXEC: begin
                case (opcode)
                    OP_ADD, OP_AND: begin
                        rf_r_addr_0 = base;
                        a_sel       = 1'b1;
                        b_sel       = ir[5];
                        rf_r_addr_1 = ir[2:0];
                        sext_sel    = SEXT_IMM5;
                        alu_sel     = (opcode == OP_ADD) ? ALU_ADD : ALU_AND;
                        rf_w_sel    = W_ALU;
                        rf_w_addr   = dr;
                        rf_w_en     = 1'b1;
                        nzp_ld      = 1'b1;
                    end
                    OP_NOT: begin
                        rf_r_addr_0 = base;
                        a_sel       = 1'b1;
                        alu_sel     = ALU_NOT;
                        rf_w_sel    = W_ALU;
                        rf_w_addr   = dr;
                        rf_w_en     = 1'b1;
                        nzp_ld      = 1'b1;
                    end
                    OP_BR: begin
                        // PC already points past the branch, so PC + off9 is the target.
                        if (br_taken) begin
                            pc_ld      = 1'b1;
                            pc_add_sel = 1'b1;
                        end
                    end
                    OP_JMP: begin
                        rf_r_addr_0 = base;
                        a_sel       = 1'b1;
                        alu_sel     = ALU_PASS;
                        pc_data_sel = 1'b1;
                        pc_ld       = 1'b1;
                    end
                    OP_JSR: begin
                        // R7 captures the incremented PC on the same edge the PC reloads;
                        // the base register is read before that edge, so JSRR R7 uses old R7.
                        rf_w_addr = 3'd7;
                        rf_w_sel  = W_PC;
                        rf_w_en   = 1'b1;
                        pc_ld     = 1'b1;
                        if (ir[11]) begin
                            pc_add_sel = 1'b0;
                        end else begin
                            rf_r_addr_0 = base;
                            a_sel       = 1'b1;
                            alu_sel     = ALU_PASS;
                            pc_data_sel = 1'b1;
                        end
                    end
                    OP_LD: begin
                        mem_addr_sel = MEM_ALU;
                        a_sel        = 1'b0;
                        b_sel        = 1'b1;
                        sext_sel     = SEXT_OFF9;
                        alu_sel      = ALU_ADD;
                        rf_w_sel     = W_MEM;
                        rf_w_addr    = dr;
                        rf_w_en      = 1'b1;
                        nzp_ld       = 1'b1;
                    end
                    OP_LDR: begin
                        mem_addr_sel = MEM_ALU;
                        rf_r_addr_0  = base;
                        a_sel        = 1'b1;
                        b_sel        = 1'b1;
                        sext_sel     = SEXT_OFF6;
                        alu_sel      = ALU_ADD;
                        rf_w_sel     = W_MEM;
                        rf_w_addr    = dr;
                        rf_w_en      = 1'b1;
                        nzp_ld       = 1'b1;
                    end
                    OP_LEA: begin
                        a_sel     = 1'b0;
                        b_sel     = 1'b1;
                        sext_sel  = SEXT_OFF9;
                        alu_sel   = ALU_ADD;
                        rf_w_sel  = W_ALU;
                        rf_w_addr = dr;
                        rf_w_en   = 1'b1;
                    end
                    OP_ST: begin
                        mem_addr_sel = MEM_ALU;
                        a_sel        = 1'b0;
                        b_sel        = 1'b1;
                        sext_sel     = SEXT_OFF9;
                        alu_sel      = ALU_ADD;
                        rf_r_addr_1  = dr;
                        mem_w_en     = 1'b1;
                    end
                    OP_STR: begin
                        mem_addr_sel = MEM_ALU;
                        rf_r_addr_0  = base;
                        a_sel        = 1'b1;
                        b_sel        = 1'b1;
                        sext_sel     = SEXT_OFF6;
                        alu_sel      = ALU_ADD;
                        rf_r_addr_1  = dr;
                        mem_w_en     = 1'b1;
                    end
                    OP_LDI, OP_STI: begin
                        // First hop: fetch the pointer into the store register.
                        mem_addr_sel = MEM_ALU;
                        a_sel        = 1'b0;
                        b_sel        = 1'b1;
                        sext_sel     = SEXT_OFF9;
                        alu_sel      = ALU_ADD;
                        store_ld     = 1'b1;
                    end
                    default: begin
                        // RTI, reserved and non-halt TRAP retire as no-ops.
                    end
                endcase
            end

            EXEC2: begin
                // Second hop: the store register supplies the effective address.
                mem_addr_sel = MEM_STORE;
                if (opcode == OP_LDI) begin
                    rf_w_sel  = W_MEM;
                    rf_w_addr = dr;
                    rf_w_en   = 1'b1;
                    nzp_ld    = 1'b1;
                end else if (opcode == OP_STI) begin
                    rf_r_addr_1 = dr;
                    mem_w_en    = 1'b1;
                end
            end

            HALT: begin
                halted = 1'b1;
            end

            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_punc_control.sv
// Purpose: self-checking bench for punc_control against a per-instruction control model.
// Latency: checks every cycle of each instruction, sampled on the falling clock edge.
// Backpressure: none; stimulus drives IR/flags freely each cycle.
module tb_punc_control;

    typedef struct packed {
        logic       pc_ld;
        logic       pc_inc;
        logic       pc_data_sel;
        logic       pc_add_sel;
        logic       ir_ld;
        logic [1:0] mem_addr_sel;
        logic       mem_w_en;
        logic       store_ld;
        logic [2:0] rf_r_addr_0;
        logic [2:0] rf_r_addr_1;
        logic [2:0] rf_w_addr;
        logic       rf_w_en;
        logic [1:0] rf_w_sel;
        logic       a_sel;
        logic       b_sel;
        logic [1:0] sext_sel;
        logic [1:0] alu_sel;
        logic       nzp_ld;
        logic       halted;
    } ctl_t;

    localparam int P_FETCH  = 0;
    localparam int P_DECODE = 1;
    localparam int P_EXEC   = 2;
    localparam int P_EXEC2  = 3;
    localparam int P_HALT   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ir;
    logic        n_flag, z_flag, p_flag;
    logic        pc_ld, pc_inc, pc_data_sel, pc_add_sel, ir_ld;
    logic [1:0]  mem_addr_sel;
    logic        mem_w_en, store_ld;
    logic [2:0]  rf_r_addr_0, rf_r_addr_1, rf_w_addr;
    logic        rf_w_en;
    logic [1:0]  rf_w_sel;
    logic        a_sel, b_sel;
    logic [1:0]  sext_sel, alu_sel;
    logic        nzp_ld, halted;

    int checks = 0;
    int errors = 0;

    ctl_t obs;
    assign obs = {pc_ld, pc_inc, pc_data_sel, pc_add_sel, ir_ld, mem_addr_sel, mem_w_en,
                  store_ld, rf_r_addr_0, rf_r_addr_1, rf_w_addr, rf_w_en, rf_w_sel,
                  a_sel, b_sel, sext_sel, alu_sel, nzp_ld, halted};

    always #5 clk = ~clk;

    punc_control #(.HALT_VECT(8'h25)) dut (
        .clk(clk), .rst(rst), .ir(ir),
        .n_flag(n_flag), .z_flag(z_flag), .p_flag(p_flag),
        .pc_ld(pc_ld), .pc_inc(pc_inc), .pc_data_sel(pc_data_sel), .pc_add_sel(pc_add_sel),
        .ir_ld(ir_ld), .mem_addr_sel(mem_addr_sel), .mem_w_en(mem_w_en), .store_ld(store_ld),
        .rf_r_addr_0(rf_r_addr_0), .rf_r_addr_1(rf_r_addr_1), .rf_w_addr(rf_w_addr),
        .rf_w_en(rf_w_en), .rf_w_sel(rf_w_sel), .a_sel(a_sel), .b_sel(b_sel),
        .sext_sel(sext_sel), .alu_sel(alu_sel), .nzp_ld(nzp_ld), .halted(halted)
    );

    // Datapath recipes the instruction set is built from.
    function automatic ctl_t addr_pc_off9(input ctl_t c);
        ctl_t r = c;
        r.mem_addr_sel = 2'b01; r.a_sel = 1'b0; r.b_sel = 1'b1; r.sext_sel = 2'b10; r.alu_sel = 2'b00;
        return r;
    endfunction

    function automatic ctl_t addr_base_off6(input ctl_t c, input logic [2:0] base);
        ctl_t r = c;
        r.mem_addr_sel = 2'b01; r.rf_r_addr_0 = base; r.a_sel = 1'b1; r.b_sel = 1'b1;
        r.sext_sel = 2'b01; r.alu_sel = 2'b00;
        return r;
    endfunction

    function automatic ctl_t write_reg(input ctl_t c, input logic [2:0] dst, input logic [1:0] src, input logic cc);
        ctl_t r = c;
        r.rf_w_addr = dst; r.rf_w_sel = src; r.rf_w_en = 1'b1; r.nzp_ld = cc;
        return r;
    endfunction

    // Expected controls for one cycle of an instruction, given its phase.
    function automatic ctl_t model(input int ph, input logic [15:0] i, input logic [2:0] nzp);
        ctl_t c;
        logic [3:0] op;
        logic [2:0] dr, base;
        c = '0; op = i[15:12]; dr = i[11:9]; base = i[8:6];
        if (ph == P_FETCH) begin
            c.ir_ld = 1'b1; c.pc_inc = 1'b1;
        end else if (ph == P_HALT) begin
            c.halted = 1'b1;
        end else if (ph == P_EXEC2) begin
            c.mem_addr_sel = 2'b10;
            if (op == 4'hA) c = write_reg(c, dr, 2'b01, 1'b1);
            else begin c.mem_w_en = 1'b1; c.rf_r_addr_1 = dr; end
        end else if (ph == P_EXEC) begin
            case (op)
                4'h1, 4'h5: begin
                    c.rf_r_addr_0 = base; c.a_sel = 1'b1; c.b_sel = i[5]; c.rf_r_addr_1 = i[2:0];
                    c.alu_sel = (op == 4'h1) ? 2'b00 : 2'b01;
                    c = write_reg(c, dr, 2'b10, 1'b1);
                end
                4'h9: begin
                    c.rf_r_addr_0 = base; c.a_sel = 1'b1; c.alu_sel = 2'b10;
                    c = write_reg(c, dr, 2'b10, 1'b1);
                end
                4'h0: if ((i[11:9] & nzp) != 3'b000) begin c.pc_ld = 1'b1; c.pc_add_sel = 1'b1; end
                4'hC: begin
                    c.rf_r_addr_0 = base; c.a_sel = 1'b1; c.alu_sel = 2'b11; c.pc_data_sel = 1'b1; c.pc_ld = 1'b1;
                end
                4'h4: begin
                    c = write_reg(c, 3'd7, 2'b00, 1'b0); c.pc_ld = 1'b1;
                    if (!i[11]) begin
                        c.rf_r_addr_0 = base; c.a_sel = 1'b1; c.alu_sel = 2'b11; c.pc_data_sel = 1'b1;
                    end
                end
                4'h2: c = write_reg(addr_pc_off9(c), dr, 2'b01, 1'b1);
                4'h6: c = write_reg(addr_base_off6(c, base), dr, 2'b01, 1'b1);
                4'hE: begin
                    c.b_sel = 1'b1; c.sext_sel = 2'b10;
                    c = write_reg(c, dr, 2'b10, 1'b0);
                end
                4'h3: begin c = addr_pc_off9(c); c.rf_r_addr_1 = dr; c.mem_w_en = 1'b1; end
                4'h7: begin c = addr_base_off6(c, base); c.rf_r_addr_1 = dr; c.mem_w_en = 1'b1; end
                4'hA, 4'hB: begin c = addr_pc_off9(c); c.store_ld = 1'b1; end
                default: ;
            endcase
        end
        return c;
    endfunction

    task automatic chk_vec(input string tag, input ctl_t o, input ctl_t e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    task automatic chk_bit(input string tag, input logic o, input logic e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, o, e);
        end
    endtask

    // Runs one instruction from FETCH; entered and left at 1 time unit after a rising edge.
    task automatic run_instr(input logic [15:0] i, input bit rand_flags, input logic [2:0] fl, input int halt_cycles);
        int phases[$];
        logic [3:0] op;
        op = i[15:12];
        phases = '{P_FETCH, P_DECODE};
        if (i == 16'hF025) begin
            for (int k = 0; k < halt_cycles; k++) phases.push_back(P_HALT);
        end else begin
            phases.push_back(P_EXEC);
            if (op == 4'hA || op == 4'hB) phases.push_back(P_EXEC2);
        end
        ir = i;
        foreach (phases[k]) begin
            {n_flag, z_flag, p_flag} = rand_flags ? 3'($urandom) : fl;
            @(negedge clk);
            chk_vec($sformatf("ir=%h phase=%0d", i, phases[k]), obs,
                    model(phases[k], i, {n_flag, z_flag, p_flag}));
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [15:0] r;
        rst = 1'b0; ir = 16'h0000; {n_flag, z_flag, p_flag} = 3'b000;

        // Held in reset: FETCH controls, not halted.
        repeat (2) @(posedge clk);
        #1;
        chk_vec("reset_state", obs, model(P_FETCH, 16'h0000, 3'b000));
        chk_bit("reset_halted", halted, 1'b0);
        rst = 1'b1;

        // ADD R1,R1,#1 then a follow-up proving the return to FETCH.
        run_instr(16'h1261, 1'b0, 3'b000, 0);
        run_instr(16'h5A85, 1'b1, 3'b000, 0);

        // BRz taken and not taken.
        run_instr(16'h0402, 1'b0, 3'b010, 0);
        run_instr(16'h0402, 1'b0, 3'b101, 0);
        run_instr(16'h0E00, 1'b0, 3'b001, 0);
        run_instr(16'h0000, 1'b0, 3'b111, 0);

        // LDI (4 cycles), STI, JSRR R7, JSR, JMP, LEA, NOT, ST, STR, LD, LDR, RTI, non-halt TRAP.
        run_instr(16'hA405, 1'b1, 3'b000, 0);
        run_instr(16'hB7F0, 1'b1, 3'b000, 0);
        run_instr(16'h41C0, 1'b1, 3'b000, 0);
        run_instr(16'h4812, 1'b1, 3'b000, 0);
        run_instr(16'hC1C0, 1'b1, 3'b000, 0);
        run_instr(16'hE7FF, 1'b1, 3'b000, 0);
        run_instr(16'h96BF, 1'b1, 3'b000, 0);
        run_instr(16'h3003, 1'b1, 3'b000, 0);
        run_instr(16'h7A7F, 1'b1, 3'b000, 0);
        run_instr(16'h2C10, 1'b1, 3'b000, 0);
        run_instr(16'h6D41, 1'b1, 3'b000, 0);
        run_instr(16'h8000, 1'b1, 3'b000, 0);
        run_instr(16'hF023, 1'b1, 3'b000, 0);
        run_instr(16'hD123, 1'b1, 3'b000, 0);

        // Random instruction stream (halt word excluded).
        for (int n = 0; n < 400; n++) begin
            r = 16'($urandom);
            if (r == 16'hF025) r = 16'hF024;
            run_instr(r, 1'b1, 3'b000, 0);
        end

        // HALT: sticky; async reset clears it mid-cycle; FETCH on release.
        run_instr(16'hF025, 1'b1, 3'b000, 4);
        #2 rst = 1'b0;
        #1;
        chk_bit("halt_reset_halted", halted, 1'b0);
        chk_vec("halt_reset_vec", obs, model(P_FETCH, ir, 3'b000));
        @(posedge clk);
        #1 rst = 1'b1;
        run_instr(16'h1261, 1'b1, 3'b000, 0);

        // Reset during ST's EXEC kills the write immediately.
        ir = 16'h3003;
        {n_flag, z_flag, p_flag} = 3'b000;
        @(negedge clk);
        chk_vec("st_fetch", obs, model(P_FETCH, ir, 3'b000));
        @(posedge clk); #1;
        @(negedge clk);
        chk_vec("st_decode", obs, model(P_DECODE, ir, 3'b000));
        @(posedge clk); #1;
        @(negedge clk);
        chk_bit("st_exec_wen", mem_w_en, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk_bit("st_reset_wen", mem_w_en, 1'b0);
        chk_vec("st_reset_vec", obs, model(P_FETCH, ir, 3'b000));
        @(posedge clk);
        #1;
        chk_bit("st_reset_hold_wen", mem_w_en, 1'b0);
        rst = 1'b1;
        run_instr(16'h3003, 1'b1, 3'b000, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/punc_control.md
Name: punc_control

Overview:
- FSM control unit for the PUnC LC3 processor.
- Decodes the latched instruction register and current NZP flags.
- Each cycle, drives every select, load and write-enable consumed by the PUnC datapath.
- Sits directly upstream of the datapath; all outputs feed datapath control ports.

Parameters:
- HALT_VECT, 8'h25, TRAP vector that halts the machine.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- ir  in  16  instruction register contents from datapath.
- n_flag, z_flag, p_flag  in  1 each  datapath condition codes.
- pc_ld  out  1  load PC from pc_data_sel source.
- pc_inc  out  1  PC <= PC+1.
- pc_data_sel  out  1  0 = PC adder, 1 = ALU result (base register).
- pc_add_sel  out  1  0 = sext offset11, 1 = sext offset9.
- ir_ld  out  1  IR <= mem[PC].
- mem_addr_sel  out  2  00 = PC, 01 = adder/ALU address, 10 = store reg.
- mem_w_en  out  1  memory write.
- store_ld  out  1  store reg <= memory read data.
- rf_r_addr_0, rf_r_addr_1, rf_w_addr  out  3 each  register file addresses.
- rf_w_en  out  1  register file write.
- rf_w_sel  out  2  00 = PC, 01 = mem data, 10 = ALU.
- a_sel  out  1  0 = PC, 1 = rf read 0.
- b_sel  out  1  0 = rf read 1, 1 = sext value.
- sext_sel  out  2  00 = imm5, 01 = off6, 10 = off9, 11 = off11.
- alu_sel  out  2  00 = ADD, 01 = AND, 10 = NOT, 11 = PASS A.
- nzp_ld  out  1  update condition codes from rf write data.
- halted  out  1  machine halted.

Behaviour:
- States: FETCH, DECODE, EXEC, EXEC2, HALT. State register only; all outputs combinational from state and ir.
- Defaults: every enable, load and write output is 0 unless listed below.
- Reset (rst = 0, asynchronous): state = FETCH, halted = 0. All outputs take their FETCH values once reset releases.
- FETCH:
  - ir_ld = 1, pc_inc = 1, mem_addr_sel = 00.
  - Next state: DECODE.
- DECODE:
  - No enables asserted.
  - Next state: EXEC, or HALT when ir = {4'b1111, 4'b0000, HALT_VECT}.
- EXEC, by opcode ir[15:12]; next state FETCH unless stated:
  - ADD/AND (0001/0101):
    - rf_r_addr_0 = ir[8:6], a_sel = 1.
    - b_sel = ir[5]; rf_r_addr_1 = ir[2:0], sext_sel = 00.
    - alu_sel = ADD/AND, rf_w_sel = 10, rf_w_addr = ir[11:9], rf_w_en = 1, nzp_ld = 1.
  - NOT (1001): as ADD/AND with alu_sel = 10 and b ignored.
  - BR (0000):
    - pc_ld = 1, pc_data_sel = 0, pc_add_sel = 1 only when (ir[11]&n_flag)|(ir[10]&z_flag)|(ir[9]&p_flag).
    - ir[11:9] = 000 is a no-op.
  - JMP/RET (1100): rf_r_addr_0 = ir[8:6], a_sel = 1, alu_sel = 11, pc_data_sel = 1, pc_ld = 1.
  - JSR/JSRR (0100):
    - rf_w_addr = 7, rf_w_sel = 00, rf_w_en = 1, pc_ld = 1.
    - ir[11] = 1: pc_add_sel = 0.
    - ir[11] = 0: base ir[8:6] via PASS A, pc_data_sel = 1.
    - R7 write and PC load occur on the same edge. R7 captures the pre-jump (already incremented) PC; JSRR R7 jumps to old R7.
  - LD (0010): mem_addr_sel = 01 (PC+off9), rf_w_sel = 01, rf_w_en = 1, nzp_ld = 1.
  - LDR (0110): address = rf[ir[8:6]] + sext off6; otherwise as LD.
  - LEA (1110): a_sel = 0, b_sel = 1, sext_sel = 10, alu_sel = ADD, rf_w_sel = 10, rf_w_en = 1, nzp_ld = 0.
  - ST (0011): mem_addr_sel = 01 (PC+off9), rf_r_addr_1 = ir[11:9], mem_w_en = 1.
  - STR (0111): address = base+off6; otherwise as ST.
  - LDI/STI (1010/1011): mem_addr_sel = 01 (PC+off9), store_ld = 1; next state EXEC2.
  - RTI (1000), reserved (1101), non-halt TRAP: no-op.
- EXEC2:
  - mem_addr_sel = 10.
  - LDI: rf_w_sel = 01, rf_w_en = 1, nzp_ld = 1.
  - STI: mem_w_en = 1.
  - Next state: FETCH.
- HALT: halted = 1, all enables 0; remains until reset.
- Instruction latency: 3 cycles, 4 for LDI/STI.
- Reset mid-EXEC wins immediately; no write completes after the asserting edge.

Test Plan:
- Reset and fetch:
  - Stimulus: rst low 2 cycles, release; ir = 16'h1261 (ADD R1,R1,#1).
  - Response: FETCH, DECODE, EXEC with rf_w_en = 1, rf_w_addr = 1, b_sel = 1, alu_sel = 00, nzp_ld = 1; back in FETCH on cycle 4.
- BR taken/not taken:
  - Stimulus: ir = 16'h0402 (BRz) with z_flag = 1, then with z_flag = 0.
  - Response: pc_ld = 1, pc_add_sel = 1 in the first case; pc_ld = 0 in the second.
- LDI:
  - Stimulus: ir = 16'hA405.
  - Response: EXEC store_ld = 1, mem_addr_sel = 01; EXEC2 mem_addr_sel = 10, rf_w_en = 1, rf_w_addr = 2; 4-cycle total.
- JSRR R7:
  - Stimulus: ir = 16'h41C0.
  - Response: in EXEC, rf_w_en = 1, rf_w_addr = 7, rf_w_sel = 00, pc_ld = 1, pc_data_sel = 1, rf_r_addr_0 = 7 in the same cycle.
- HALT then reset:
  - Stimulus: ir = 16'hF025, then rst pulsed low mid-HALT.
  - Response: halted = 1 from cycle 3 with all enables 0; halted = 0 asynchronously on rst low; FETCH on release.
- Reset during EXEC:
  - Stimulus: ir = 16'h3003 (ST); rst asserted low asynchronously during EXEC.
  - Response: mem_w_en drops to 0 immediately; state = FETCH.
